wb_rr_arbiter: RTL and testbench
================================

WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous active-high reset, rst; all state SHALL update only on the rising edge of clk.
REQ-002 Parameter TIMEOUT, default 255: stalled-strobe cycles before a bus error; 0 disables the watchdog.
REQ-003 Port clk, input, 1: system clock.
REQ-004 Port rst, input, 1: synchronous active-high reset.
REQ-005 Ports m0_adr_i / m1_adr_i, input, 32: master address.
REQ-006 Ports m0_dat_i / m1_dat_i, input, 32: master write data.
REQ-007 Ports m0_dat_o / m1_dat_o, output, 32: read data returned to the master.
REQ-008 Ports m0_we_i / m1_we_i, m0_cyc_i / m1_cyc_i and m0_stb_i / m1_stb_i, input, 1 each: Wishbone master controls.
REQ-009 Ports m0_sel_i / m1_sel_i, input, 4: byte selects.
REQ-010 Ports m0_ack_o / m1_ack_o and m0_err_o / m1_err_o, output, 1 each: termination to the master.
REQ-011 Ports s_adr_o and s_dat_o, output, 32; s_sel_o, output, 4; s_we_o, s_cyc_o and s_stb_o, output, 1 each: toward the interconnect master port.
REQ-012 Ports s_dat_i, input, 32, and s_ack_i, input, 1: slave response.
REQ-013 Port grant_o, output, 2: one-hot current owner (bit0 = m0, bit1 = m1, 00 = idle).

Function
REQ-014 The FSM SHALL have the states IDLE, BUS_M0 and BUS_M1.
REQ-015 In IDLE, a single asserted cyc SHALL move the FSM to that master's BUS state on the next edge; s_cyc_o then rises one cycle after the request.
REQ-016 In IDLE with both cyc asserted, the master other than last_grant SHALL win (round robin).
REQ-017 In BUS_Mn, s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o and s_stb_o SHALL be combinational copies of master n's signals.
REQ-018 In BUS_Mn, mn_ack_o SHALL equal s_ack_i and mn_dat_o SHALL equal s_dat_i.
REQ-019 The non-granted master's ack_o and err_o SHALL be 0 and its dat_o SHALL be 0.
REQ-020 In IDLE, all s_* outputs SHALL be 0.
REQ-021 Grant SHALL be held while the owner's cyc is high, regardless of the other master.
REQ-022 When the owner drops cyc, the next state SHALL be the other master's BUS state if its cyc is high (no idle bubble), otherwise IDLE.
REQ-023 last_grant SHALL update to the releasing master at that same edge.
REQ-024 Watchdog: a counter of width clog2(TIMEOUT+1) SHALL increment each cycle with s_stb_o=1 and s_ack_i=0, and clear on s_ack_i, when stb is low, or on a grant change.
REQ-025 When the counter equals TIMEOUT, the arbiter SHALL pulse mn_err_o for one cycle and force s_cyc_o/s_stb_o to 0 during that cycle.
REQ-026 After a timeout the counter SHALL clear; the grant SHALL be kept until the owner drops cyc.
REQ-027 If s_ack_i arrives in the same cycle the counter reaches TIMEOUT, ack SHALL win and err_o SHALL stay 0.
REQ-028 grant_o SHALL be registered: 01 in BUS_M0, 10 in BUS_M1, 00 in IDLE.

Reset
REQ-029 On rst: state IDLE, last_grant = m1 (so m0 wins the first tie), counter 0, grant_o 00.
REQ-030 All ack_o and err_o SHALL be 0 during and after reset, and all s_* outputs SHALL be 0.
REQ-031 A reset mid-transfer SHALL abandon the transfer without emitting ack or err.

Structure
REQ-032 The shared package mips_wb_pkg SHALL hold the state encoding, the Wishbone address/data/select widths, and the default TIMEOUT.
REQ-033 The watchdog SHALL be a sub-module, wb_watchdog, with inputs clk, rst, clr, stall and output expire.

Verification
REQ-034 m0 single read to 0x200 with ack after 2 cycles -> s_cyc_o rises 1 cycle after m0_cyc_i, m0_dat_o = s_dat_i at ack, grant_o = 01.
REQ-035 m0 and m1 request together out of reset -> m0 served first; on m0 release, m1 granted next edge with no IDLE cycle.
REQ-036 Both masters continuously re-request after each release -> grants alternate m0, m1, m0, m1.
REQ-037 TIMEOUT = 4, slave never acks -> m0_err_o pulses exactly at the 4th stalled cycle, s_stb_o is 0 that cycle, and the grant is held until m0 drops cyc.
REQ-038 TIMEOUT = 4 with ack on the 4th stalled cycle -> ack seen, no err.
REQ-039 rst asserted mid m1 write to 0x404 -> next cycle grant_o = 00, s_cyc_o = 0, no ack or err.

Source files
------------

// File: rtl/mips_wb_pkg.sv
// Shared definitions for the two-master Wishbone round-robin arbiter:
// bus widths, default watchdog limit and the arbiter state encoding.
package mips_wb_pkg;

  localparam int ADR_W       = 32;
  localparam int DAT_W       = 32;
  localparam int SEL_W       = 4;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUS_M0 = 2'd1,
    ST_BUS_M1 = 2'd2
  } wb_state_e;

  // One-hot owner vector for a given state (bit0 = m0, bit1 = m1).
  function automatic logic [1:0] grant_of(input wb_state_e s);
    case (s)
      ST_BUS_M0: return 2'b01;
      ST_BUS_M1: return 2'b10;
      default:   return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Stall watchdog: counts consecutive stalled strobe cycles and flags the
// cycle that would be the TIMEOUT-th stall. TIMEOUT = 0 never expires.
module wb_watchdog
  import mips_wb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic stall,
  output logic expire
);

  localparam int              CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]   LAST   = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit              ENABLE = (TIMEOUT > 0);

  logic [CW-1:0] r_cnt;
  logic          w_hit;

  // The counter holds the number of stalls already seen, so the current
  // stalled cycle is the TIMEOUT-th one when the count equals TIMEOUT-1.
  assign w_hit  = ENABLE && stall && !clr && (r_cnt == LAST);
  assign expire = w_hit;

  // Count stalled cycles; restart on clear or after firing.
  always_ff @(posedge clk) begin
    if (rst || clr || w_hit) begin
      r_cnt <= '0;
    end else if (stall) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Two-master Wishbone round-robin arbiter with a stall watchdog that
// terminates a hung strobe with a one-cycle err pulse.
module wb_rr_arbiter
  import mips_wb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [DAT_W-1:0] m0_dat_i,
  output logic [DAT_W-1:0] m0_dat_o,
  input  logic             m0_we_i,
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  input  logic [SEL_W-1:0] m0_sel_i,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [DAT_W-1:0] m1_dat_i,
  output logic [DAT_W-1:0] m1_dat_o,
  input  logic             m1_we_i,
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  input  logic [SEL_W-1:0] m1_sel_i,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic [DAT_W-1:0] s_dat_o,
  output logic [SEL_W-1:0] s_sel_o,
  output logic             s_we_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  input  logic [DAT_W-1:0] s_dat_i,
  input  logic             s_ack_i,
  output logic [1:0]       grant_o
);

  wb_state_e  r_state;
  wb_state_e  w_state_next;
  logic       r_last_m1;   // last_grant: 1 = m1 released last, 0 = m0
  logic [1:0] r_grant;
  logic       w_release;
  logic       w_grant_chg;
  logic       w_sel_m0;
  logic       w_sel_m1;
  logic       w_own_cyc;
  logic       w_own_stb;
  logic       w_stb_live;
  logic       w_stall;
  logic       w_wd_clr;
  logic       w_expire;

  // Next owner: hold while the owner keeps cyc, hand over without a bubble.
  always_comb begin
    w_state_next = r_state;
    w_release    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          w_state_next = r_last_m1 ? ST_BUS_M0 : ST_BUS_M1;
        end else if (m0_cyc_i) begin
          w_state_next = ST_BUS_M0;
        end else if (m1_cyc_i) begin
          w_state_next = ST_BUS_M1;
        end
      end
      ST_BUS_M0: begin
        if (!m0_cyc_i) begin
          w_release    = 1'b1;
          w_state_next = m1_cyc_i ? ST_BUS_M1 : ST_IDLE;
        end
      end
      ST_BUS_M1: begin
        if (!m1_cyc_i) begin
          w_release    = 1'b1;
          w_state_next = m0_cyc_i ? ST_BUS_M0 : ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Arbiter FSM with registered grant and last-owner memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_last_m1 <= 1'b1;
      r_grant   <= 2'b00;
    end else begin
      r_state <= w_state_next;
      r_grant <= grant_of(w_state_next);
      if (w_release) begin
        r_last_m1 <= (r_state == ST_BUS_M1);
      end
    end
  end

  // Owner decode is gated by reset so a transfer in flight is abandoned
  // immediately, with no ack or err leaking out during reset.
  assign w_sel_m0    = !rst && (r_state == ST_BUS_M0);
  assign w_sel_m1    = !rst && (r_state == ST_BUS_M1);
  assign w_grant_chg = (w_state_next != r_state);

  assign w_own_cyc  = (w_sel_m0 && m0_cyc_i) || (w_sel_m1 && m1_cyc_i);
  assign w_own_stb  = (w_sel_m0 && m0_stb_i) || (w_sel_m1 && m1_stb_i);
  assign w_stb_live = w_own_cyc && w_own_stb;
  assign w_stall    = w_stb_live && !s_ack_i;
  assign w_wd_clr   = w_grant_chg || !w_stb_live || s_ack_i;

  wb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_wd_clr),
    .stall (w_stall),
    .expire(w_expire)
  );

  // Request path toward the slave: copy of the owner, zero when idle.
  assign s_adr_o = w_sel_m0 ? m0_adr_i : (w_sel_m1 ? m1_adr_i : '0);
  assign s_dat_o = w_sel_m0 ? m0_dat_i : (w_sel_m1 ? m1_dat_i : '0);
  assign s_sel_o = w_sel_m0 ? m0_sel_i : (w_sel_m1 ? m1_sel_i : '0);
  assign s_we_o  = (w_sel_m0 && m0_we_i) || (w_sel_m1 && m1_we_i);
  assign s_cyc_o = w_own_cyc && !w_expire;
  assign s_stb_o = w_own_stb && !w_expire;

  // Response path: only the owner sees the slave; the other master reads zero.
  assign m0_ack_o = w_sel_m0 && s_ack_i;
  assign m1_ack_o = w_sel_m1 && s_ack_i;
  assign m0_err_o = w_sel_m0 && w_expire;
  assign m1_err_o = w_sel_m1 && w_expire;
  assign m0_dat_o = w_sel_m0 ? s_dat_i : '0;
  assign m1_dat_o = w_sel_m1 ? s_dat_i : '0;

  assign grant_o = r_grant;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Scoreboard bench for wb_rr_arbiter (TIMEOUT = 4): directed stimulus
// pushes expected terminations, a monitor branch pops them on ack/err.
module tb_wb_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] m0_adr_i = '0, m0_dat_i = '0, m0_dat_o;
  logic        m0_we_i = 1'b0, m0_cyc_i = 1'b0, m0_stb_i = 1'b0;
  logic [3:0]  m0_sel_i = '0;
  logic        m0_ack_o, m0_err_o;
  logic [31:0] m1_adr_i = '0, m1_dat_i = '0, m1_dat_o;
  logic        m1_we_i = 1'b0, m1_cyc_i = 1'b0, m1_stb_i = 1'b0;
  logic [3:0]  m1_sel_i = '0;
  logic        m1_ack_o, m1_err_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_cyc_o, s_stb_o;
  logic [31:0] s_dat_i = '0;
  logic        s_ack_i = 1'b0;
  logic [1:0]  grant_o;

  // term = {m1_err, m0_err, m1_ack, m0_ack}
  typedef struct packed {
    logic [3:0]  term;
    logic [31:0] d0;
    logic [31:0] d1;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  wb_rr_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
    .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
    .m0_sel_i(m0_sel_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
    .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
    .m1_sel_i(m1_sel_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .grant_o(grant_o)
  );

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic push(input logic [3:0] term, input logic [31:0] d0, input logic [31:0] d1);
    exp_t e;
    e.term = term;
    e.d0   = d0;
    e.d1   = d1;
    exp_q.push_back(e);
  endtask

  task automatic req(input int m, input logic on, input logic [31:0] adr,
                     input logic we, input logic [31:0] dat);
    if (m == 0) begin
      m0_cyc_i = on; m0_stb_i = on; m0_adr_i = adr; m0_we_i = we;
      m0_dat_i = dat; m0_sel_i = on ? 4'hF : 4'h0;
    end else begin
      m1_cyc_i = on; m1_stb_i = on; m1_adr_i = adr; m1_we_i = we;
      m1_dat_i = dat; m1_sel_i = on ? 4'hF : 4'h0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    fork
      // Monitor: every ack/err the DUT presents must match the next expectation.
      begin
        forever begin
          exp_t act;
          exp_t e;
          @(negedge clk);
          act.term = {m1_err_o, m0_err_o, m1_ack_o, m0_ack_o};
          act.d0   = m0_dat_o;
          act.d1   = m1_dat_o;
          if (act.term != 4'b0000) begin
            if (exp_q.size() == 0) begin
              n_vec++;
              n_err++;
              $display("FAIL unexpected_term: got %h, expected no termination", act);
            end else begin
              e = exp_q.pop_front();
              $display("txn t=%0t term=%b d0=%h d1=%h", $time, act.term, act.d0, act.d1);
              chk("term", act, e);
            end
          end
        end
      end
      // Directed stimulus.
      begin
        logic owner;
        // Reset state
        at_neg();
        chk("rst_grant", 68'(grant_o), 68'(2'b00));
        chk("rst_scyc", 68'({s_cyc_o, s_stb_o, s_we_o}), 68'(3'b000));
        chk("rst_sadr", 68'(s_adr_o), 68'h0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Single m0 read to 0x200, ack two cycles after grant
        req(0, 1'b1, 32'h0000_0200, 1'b0, 32'h0);
        at_neg();
        chk("s1_scyc_req_cycle", 68'(s_cyc_o), 68'(1'b0));
        tick();
        at_neg();
        chk("s1_scyc_next", 68'(s_cyc_o), 68'(1'b1));
        chk("s1_grant", 68'(grant_o), 68'(2'b01));
        chk("s1_sadr", 68'(s_adr_o), 68'h200);
        tick(); tick();
        s_ack_i = 1'b1; s_dat_i = 32'hCAFE_0001;
        push(4'b0001, 32'hCAFE_0001, 32'h0);
        tick();
        s_ack_i = 1'b0; s_dat_i = '0;
        req(0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        at_neg();
        chk("s1_grant_idle", 68'(grant_o), 68'(2'b00));

        // Fresh reset, then simultaneous requests: m0 first, m1 with no bubble
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req(0, 1'b1, 32'h0000_0100, 1'b0, 32'h0);
        req(1, 1'b1, 32'h0000_0300, 1'b0, 32'h0);
        tick();
        s_ack_i = 1'b1; s_dat_i = 32'h0000_1234;
        push(4'b0001, 32'h0000_1234, 32'h0);
        at_neg();
        chk("s2_grant_m0", 68'(grant_o), 68'(2'b01));
        chk("s2_sadr_m0", 68'(s_adr_o), 68'h100);
        tick();
        s_ack_i = 1'b0; s_dat_i = '0;
        req(0, 1'b0, 32'h0, 1'b0, 32'h0);
        at_neg();
        chk("s2_grant_hold", 68'(grant_o), 68'(2'b01));
        tick();
        s_ack_i = 1'b1; s_dat_i = 32'h1111_2222;
        push(4'b0010, 32'h0, 32'h1111_2222);
        at_neg();
        chk("s2_grant_m1_nobubble", 68'(grant_o), 68'(2'b10));
        chk("s2_sadr_m1", 68'(s_adr_o), 68'h300);
        tick();
        s_ack_i = 1'b0; s_dat_i = '0;
        req(1, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        at_neg();
        chk("s2_grant_idle", 68'(grant_o), 68'(2'b00));

        // Continuous re-requests alternate m0, m1, m0, m1
        tick();
        req(0, 1'b1, 32'h0000_1000, 1'b0, 32'h0);
        req(1, 1'b1, 32'h0000_2000, 1'b0, 32'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
          owner = ((i % 2) == 1);
          s_ack_i = 1'b1; s_dat_i = 32'hA000_0000 + 32'(i);
          if (owner) push(4'b0010, 32'h0, 32'hA000_0000 + 32'(i));
          else       push(4'b0001, 32'hA000_0000 + 32'(i), 32'h0);
          at_neg();
          chk("s3_rr_grant", 68'(grant_o), owner ? 68'(2'b10) : 68'(2'b01));
          tick();
          s_ack_i = 1'b0; s_dat_i = '0;
          if (owner) req(1, 1'b0, 32'h0, 1'b0, 32'h0);
          else       req(0, 1'b0, 32'h0, 1'b0, 32'h0);
          tick();
          if (owner) req(1, 1'b1, 32'h0000_2000, 1'b0, 32'h0);
          else       req(0, 1'b1, 32'h0000_1000, 1'b0, 32'h0);
        end
        req(0, 1'b0, 32'h0, 1'b0, 32'h0);
        req(1, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        at_neg();
        chk("s3_grant_idle", 68'(grant_o), 68'(2'b00));

        // Watchdog: slave never acks, err on the 4th stalled cycle
        tick();
        req(0, 1'b1, 32'h0000_0500, 1'b0, 32'h0);
        tick();                          // stalled cycle 1
        at_neg();
        chk("s4_stb_c1", 68'(s_stb_o), 68'(1'b1));
        tick(); tick(); tick();          // stalled cycle 4
        push(4'b0100, 32'h0, 32'h0);
        at_neg();
        chk("s4_stb_forced", 68'({s_cyc_o, s_stb_o}), 68'(2'b00));
        tick();
        at_neg();
        chk("s4_stb_after", 68'(s_stb_o), 68'(1'b1));
        chk("s4_grant_held", 68'(grant_o), 68'(2'b01));
        tick();
        req(0, 1'b0, 32'h0, 1'b0, 32'h0);
        at_neg();
        chk("s4_grant_held_drop", 68'(grant_o), 68'(2'b01));
        tick();
        at_neg();
        chk("s4_grant_idle", 68'(grant_o), 68'(2'b00));

        // Ack on the 4th stalled cycle beats the watchdog
        tick();
        req(0, 1'b1, 32'h0000_0600, 1'b0, 32'h0);
        tick(); tick(); tick(); tick();  // stalled cycle 4
        s_ack_i = 1'b1; s_dat_i = 32'hD00D_FEED;
        push(4'b0001, 32'hD00D_FEED, 32'h0);
        at_neg();
        chk("s5_stb_kept", 68'(s_stb_o), 68'(1'b1));
        tick();
        s_ack_i = 1'b0; s_dat_i = '0;
        req(0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();

        // Reset in the middle of an m1 write to 0x404
        req(1, 1'b1, 32'h0000_0404, 1'b1, 32'h5555_AAAA);
        tick();
        at_neg();
        chk("s6_grant_m1", 68'(grant_o), 68'(2'b10));
        chk("s6_write_path", 68'({s_we_o, s_adr_o, s_dat_o}), 68'({1'b1, 32'h0000_0404, 32'h5555_AAAA}));
        tick();
        rst = 1'b1; s_ack_i = 1'b1; s_dat_i = 32'hBAD0_BAD0;
        at_neg();
        chk("s6_rst_noterm", 68'({m1_ack_o, m1_err_o, s_cyc_o}), 68'(3'b000));
        tick();
        rst = 1'b0; s_ack_i = 1'b0; s_dat_i = '0;
        req(1, 1'b0, 32'h0, 1'b0, 32'h0);
        at_neg();
        chk("s6_after_rst", 68'({grant_o, s_cyc_o}), 68'(3'b000));
        tick(); tick();
      end
    join_any
    disable fork;
    chk("scoreboard_drained", 68'(exp_q.size()), 68'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
